// File: rtl/cut_sweep_pkg.sv
// Shared types and MISR constants for the CUT sweep harness.
package cut_sweep_pkg;
  typedef enum logic [1:0] {IDLE, APPLY, EMIT, FIN} sweep_state_t;
  localparam logic [15:0] POLY = 16'h1021;
  localparam logic [15:0] SEED = 16'hFFFF;
endpackage

// File: rtl/cut_misr.sv
// Multiple-input signature register: clear to seed, shift-and-fold on enable.
module cut_misr #(
  parameter int         W    = 16,
  parameter logic [W-1:0] POLY = {{(W-1){1'b0}}, 1'b1},
  parameter logic [W-1:0] SEED = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] sig
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   sig <= SEED;
    else if (clr) sig <= SEED;
    else if (en)  sig <= {sig[W-2:0], 1'b0} ^ (sig[W-1] ? POLY : '0) ^ din;
  end
endmodule

// File: rtl/cut_sweep_sampler.sv
// Exhaustive input sweep of a combinational CUT; streams truth-table rows and a MISR signature.
module cut_sweep_sampler
  import cut_sweep_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int N_OUT  = 5,
  parameter int SIG_W  = 16,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [N_IN-1:0]  cut_in,
  input  logic [N_OUT-1:0] cut_out,
  output logic             tt_valid,
  input  logic             tt_ready,
  output logic [N_IN-1:0]  tt_row,
  output logic [N_OUT-1:0] tt_data,
  output logic [SIG_W-1:0] signature,
  output logic             sig_valid
);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   SETTLE_LD = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST_ROW  = '1;

  sweep_state_t    state, state_nx;
  logic [N_IN-1:0] row_cnt;
  logic [CW-1:0]   settle_cnt;
  logic            sig_valid_q;
  logic            accept, cap, last;

  assign accept = (state == IDLE) && start;
  assign cap    = (state == APPLY) && (settle_cnt == '0);
  assign last   = (row_cnt == LAST_ROW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = APPLY;
      APPLY:   if (cap) state_nx = EMIT;
      EMIT:    if (tt_ready) state_nx = last ? FIN : APPLY;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Terminal test happens before the increment, so row_cnt never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt     <= '0;
      settle_cnt  <= '0;
      tt_row      <= '0;
      tt_data     <= '0;
      sig_valid_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          row_cnt     <= '0;
          settle_cnt  <= SETTLE_LD;
          sig_valid_q <= 1'b0;
        end
        APPLY: if (cap) begin
          tt_row  <= row_cnt;
          tt_data <= cut_out;
        end else begin
          settle_cnt <= settle_cnt - 1'b1;
        end
        EMIT: if (tt_ready) begin
          if (last) begin
            sig_valid_q <= 1'b1;
          end else begin
            row_cnt    <= row_cnt + 1'b1;
            settle_cnt <= SETTLE_LD;
          end
        end
        default: ;
      endcase
    end
  end

  cut_misr #(.W(SIG_W), .POLY(SIG_W'(POLY)), .SEED(SIG_W'(SEED))) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (cap),
    .din   (SIG_W'(cut_out)),
    .sig   (signature)
  );

  assign busy      = (state == APPLY) || (state == EMIT);
  assign done      = (state == FIN);
  assign tt_valid  = (state == EMIT);
  assign cut_in    = row_cnt;
  assign sig_valid = sig_valid_q;
endmodule

// File: tb/tb_cut_sweep_sampler.sv
// Randomized scenario bench for cut_sweep_sampler against a truth-table/MISR reference model.
module tb_cut_sweep_sampler;
  import cut_sweep_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start0 = 1'b0, tt_ready0 = 1'b1;
  logic        busy0, done0, tt_valid0, sig_valid0;
  logic [1:0]  cut_in0, tt_row0;
  logic [4:0]  cut_out0, tt_data0;
  logic [15:0] signature0;

  logic        start1 = 1'b0, tt_ready1 = 1'b1;
  logic        busy1, done1, tt_valid1, sig_valid1;
  logic [1:0]  cut_in1, tt_row1;
  logic [4:0]  cut_out1 = 5'd0, tt_data1;
  logic [15:0] signature1;

  int n_cmp = 0, n_bad = 0;
  int mode = 0;
  logic [4:0] lut0, lut1, lut2, lut3;

  assign cut_out0 = (mode == 0) ? {3'b0, cut_in0} :
                    (mode == 1) ? 5'd0 :
                    (cut_in0 == 2'd0) ? lut0 : (cut_in0 == 2'd1) ? lut1 :
                    (cut_in0 == 2'd2) ? lut2 : lut3;

  cut_sweep_sampler #(.N_IN(2), .N_OUT(5), .SIG_W(16), .SETTLE(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
    .cut_in(cut_in0), .cut_out(cut_out0), .tt_valid(tt_valid0), .tt_ready(tt_ready0),
    .tt_row(tt_row0), .tt_data(tt_data0), .signature(signature0), .sig_valid(sig_valid0));

  cut_sweep_sampler #(.N_IN(2), .N_OUT(5), .SIG_W(16), .SETTLE(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .cut_in(cut_in1), .cut_out(cut_out1), .tt_valid(tt_valid1), .tt_ready(tt_ready1),
    .tt_row(tt_row1), .tt_data(tt_data1), .signature(signature1), .sig_valid(sig_valid1));

  // Truth table of the simulated CUT for a given row.
  function automatic logic [4:0] model_data(int m, int r);
    logic [1:0] rr;
    rr = r[1:0];
    if (m == 0) return {3'b0, rr};
    if (m == 1) return 5'd0;
    case (rr)
      2'd0: return lut0;
      2'd1: return lut1;
      2'd2: return lut2;
      default: return lut3;
    endcase
  endfunction

  // Signature expected after folding all four rows in ascending order.
  function automatic logic [15:0] ref_sig(int m);
    logic [15:0] s;
    s = SEED;
    for (int r = 0; r < 4; r++)
      s = {s[14:0], 1'b0} ^ (s[15] ? POLY : 16'h0000) ^ {11'b0, model_data(m, r)};
    return s;
  endfunction

  task automatic do_sweep(input int m, input int stall_row, input int stall_len,
                          input bit rand_rdy, input bit mid_start, input int rst_row,
                          input string tag);
    int cyc, exp_row, stalls, scnt, first_v;
    bit fin, rdy;
    logic [15:0] es;
    mode = m;
    es = ref_sig(m);
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    n_cmp++;
    if ({busy0, cut_in0, sig_valid0} !== {1'b1, 2'd0, 1'b0}) begin
      n_bad++; $display("FAIL %s start_resp: busy/cut_in/sig_valid=%b/%0d/%b want 1/0/0", tag, busy0, cut_in0, sig_valid0);
    end
    cyc = 0; exp_row = 0; stalls = 0; scnt = 0; first_v = -1; fin = 1'b0;
    while (!fin && cyc < 200) begin
      if (done0) fin = 1'b1;
      else begin
        if (rst_row >= 0 && busy0 && !tt_valid0 && cut_in0 == rst_row[1:0]) begin
          rst_n = 1'b0;
          #1;
          n_cmp++;
          if ({busy0, done0, tt_valid0, sig_valid0, cut_in0, tt_row0, tt_data0, signature0} !==
              {4'b0, 2'd0, 2'd0, 5'd0, 16'hFFFF}) begin
            n_bad++; $display("FAIL %s mid_reset: b/d/v/sv=%b%b%b%b in=%0d row=%0d data=%h sig=%h", tag,
                              busy0, done0, tt_valid0, sig_valid0, cut_in0, tt_row0, tt_data0, signature0);
          end
          @(negedge clk); rst_n = 1'b1;
          tt_ready0 = 1'b1;
          return;
        end
        if (tt_valid0) begin
          if (first_v < 0) first_v = cyc;
          n_cmp++;
          if ({tt_row0, tt_data0, cut_in0} !== {exp_row[1:0], model_data(m, exp_row), exp_row[1:0]}) begin
            n_bad++; $display("FAIL %s row%0d: row/data/cut_in=%0d/%h/%0d want %0d/%h/%0d", tag, exp_row,
                              tt_row0, tt_data0, cut_in0, exp_row, model_data(m, exp_row), exp_row);
          end
          if (rand_rdy) rdy = ($urandom_range(0, 3) != 0);
          else          rdy = !(exp_row == stall_row && scnt < stall_len);
          if (!rdy) begin stalls++; scnt++; end
          else exp_row++;
          tt_ready0 = rdy;
        end else begin
          tt_ready0 = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        start0 = mid_start && (cyc == 3);
        @(negedge clk);
        cyc++;
      end
    end
    start0 = 1'b0; tt_ready0 = 1'b1;
    n_cmp++;
    if (!fin) begin n_bad++; $display("FAIL %s timeout: no done after %0d cycles", tag, cyc); end
    n_cmp++;
    if (cyc !== 8 + stalls) begin n_bad++; $display("FAIL %s done_time: got %0d want %0d", tag, cyc, 8 + stalls); end
    n_cmp++;
    if (first_v !== 1) begin n_bad++; $display("FAIL %s first_valid: got %0d want 1", tag, first_v); end
    n_cmp++;
    if (exp_row !== 4) begin n_bad++; $display("FAIL %s row_count: got %0d want 4", tag, exp_row); end
    n_cmp++;
    if ({signature0, sig_valid0, busy0} !== {es, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL %s final: sig/sv/busy=%h/%b/%b want %h/1/0", tag, signature0, sig_valid0, busy0, es);
    end
    @(negedge clk);
    n_cmp++;
    if ({done0, sig_valid0, signature0} !== {1'b0, 1'b1, es}) begin
      n_bad++; $display("FAIL %s post_done: done/sv/sig=%b/%b/%h want 0/1/%h", tag, done0, sig_valid0, signature0, es);
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({busy0, done0, tt_valid0, sig_valid0, cut_in0, tt_row0, tt_data0, signature0} !==
        {4'b0, 2'd0, 2'd0, 5'd0, 16'hFFFF}) begin
      n_bad++; $display("FAIL reset0: b/d/v/sv=%b%b%b%b in=%0d row=%0d data=%h sig=%h",
                        busy0, done0, tt_valid0, sig_valid0, cut_in0, tt_row0, tt_data0, signature0);
    end
    n_cmp++;
    if ({busy1, done1, tt_valid1, sig_valid1, signature1} !== {4'b0, 16'hFFFF}) begin
      n_bad++; $display("FAIL reset1: b/d/v/sv=%b%b%b%b sig=%h want 0000/ffff",
                        busy1, done1, tt_valid1, sig_valid1, signature1);
    end
  endtask

  task automatic test_loopback();     do_sweep(0, -1, 0, 1'b0, 1'b0, -1, "loopback");   endtask
  task automatic test_zero();         do_sweep(1, -1, 0, 1'b0, 1'b0, -1, "zero");       endtask
  task automatic test_backpressure(); do_sweep(0, 1, 3, 1'b0, 1'b0, -1, "backpressure"); endtask
  task automatic test_start_busy();   do_sweep(0, -1, 0, 1'b0, 1'b1, -1, "start_busy"); endtask

  task automatic test_mid_reset();
    do_sweep(0, -1, 0, 1'b0, 1'b0, 2, "mid_reset");
    do_sweep(0, -1, 0, 1'b0, 1'b0, -1, "after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      lut0 = 5'($urandom); lut1 = 5'($urandom); lut2 = 5'($urandom); lut3 = 5'($urandom);
      do_sweep(2, -1, 0, 1'b1, 1'b0, -1, "random");
    end
  endtask

  // CUT output is corrupted in all but the final settle cycle of each row.
  task automatic test_settle3();
    int cyc, er, ac;
    bit fin;
    logic [15:0] es;
    es = ref_sig(0);
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    cyc = 0; er = 0; ac = 0; fin = 1'b0;
    while (!fin && cyc < 200) begin
      if (done1) fin = 1'b1;
      else begin
        if (tt_valid1) begin
          n_cmp++;
          if ({tt_row1, tt_data1} !== {er[1:0], 3'b0, er[1:0]}) begin
            n_bad++; $display("FAIL settle3 row%0d: row/data=%0d/%h want %0d/%h", er, tt_row1, tt_data1, er, {3'b0, er[1:0]});
          end
          er++; ac = 0; cut_out1 = 5'h1F;
        end else begin
          ac++;
          cut_out1 = (ac == 3) ? {3'b0, cut_in1} : ({3'b0, cut_in1} ^ 5'h15);
        end
        @(negedge clk);
        cyc++;
      end
    end
    n_cmp++;
    if (!fin) begin n_bad++; $display("FAIL settle3 timeout: no done after %0d cycles", cyc); end
    n_cmp++;
    if (cyc !== 16) begin n_bad++; $display("FAIL settle3 done_time: got %0d want 16", cyc); end
    n_cmp++;
    if ({er, signature1, sig_valid1} !== {32'd4, es, 1'b1}) begin
      n_bad++; $display("FAIL settle3 final: rows/sig/sv=%0d/%h/%b want 4/%h/1", er, signature1, sig_valid1, es);
    end
  endtask

  initial begin
    lut0 = 5'd0; lut1 = 5'd0; lut2 = 5'd0; lut3 = 5'd0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_loopback();
    test_zero();
    test_backpressure();
    test_start_busy();
    test_mid_reset();
    test_random();
    test_settle3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
